// File: rtl/systolic_array_ctrl.sv
// Sequencer for an ARRAY_DIM x ARRAY_DIM MAC grid: weight-row load, skewed vector streaming, drain.
// Optional input-starvation counter is built when TPU_STALL_COUNT_EN is defined.
module systolic_array_ctrl #(
   parameter int ARRAY_DIM = 8,
   parameter int ROW_W     = 3,
   parameter int CNT_W     = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 reload_w,
   input  logic [CNT_W-1:0]     num_vectors,
   output logic                 busy,
   output logic                 done,
   output logic                 instr,
   output logic                 w_req,
   input  logic                 w_valid,
   output logic [ROW_W-1:0]     w_row_sel,
   output logic [ARRAY_DIM-1:0] w_load_en,
   output logic                 x_req,
   input  logic                 x_valid,
   output logic [ARRAY_DIM-1:0] row_feed_en,
   output logic [ARRAY_DIM-1:0] col_valid,
   output logic [15:0]          stall_cycles
);
   typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

   state_t                 state;
   logic                   weights_loaded;
   logic [ROW_W-1:0]       row;
   logic [CNT_W-1:0]       num_lat;
   logic [CNT_W-1:0]       issued;
   logic [CNT_W-1:0]       issued_next;
   logic [2*ARRAY_DIM-1:0] pipe;
   logic                   issue;
   logic                   w_hs;

   assign w_hs        = w_req & w_valid;
   assign issue       = x_req & x_valid;
   assign issued_next = issued + CNT_W'(issue);
   assign w_row_sel   = row;
   assign row_feed_en = pipe[ARRAY_DIM-1:0];
   assign col_valid   = pipe[2*ARRAY_DIM-1:ARRAY_DIM];

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         weights_loaded <= 1'b0;
         row            <= '0;
         num_lat        <= '0;
         issued         <= '0;
         pipe           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         instr          <= 1'b0;
         w_req          <= 1'b0;
         w_load_en      <= '0;
         x_req          <= 1'b0;
      end else begin
         pipe      <= {pipe[2*ARRAY_DIM-2:0], issue};
         w_load_en <= '0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  num_lat <= num_vectors;
                  issued  <= '0;
                  row     <= '0;
                  if (reload_w || !weights_loaded) begin
                     // a partially reloaded set is no longer resident
                     weights_loaded <= 1'b0;
                     state          <= LOAD_W;
                     instr          <= 1'b1;
                     w_req          <= 1'b1;
                  end else begin
                     state <= COMPUTE;
                     x_req <= (num_vectors != '0);
                  end
               end
            end
            LOAD_W: begin
               if (w_hs) begin
                  w_load_en <= ARRAY_DIM'(1) << row;
                  row       <= row + 1'b1;
                  if (row == ROW_W'(ARRAY_DIM-1)) begin
                     weights_loaded <= 1'b1;
                     state          <= COMPUTE;
                     instr          <= 1'b0;
                     w_req          <= 1'b0;
                     x_req          <= (num_lat != '0);
                  end
               end
            end
            COMPUTE: begin
               issued <= issued_next;
               if (issued_next == num_lat) begin
                  state <= DRAIN;
                  x_req <= 1'b0;
               end
            end
            DRAIN: begin
               // leave when the shift below empties the pipe, so done lands right after the last col_valid
               if (pipe[2*ARRAY_DIM-2:0] == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TPU_STALL_COUNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clock) begin
      if (!reset)
         stall_q <= '0;
      else if (state == IDLE && start)
         stall_q <= '0;
      else if (state == COMPUTE && x_req && !x_valid && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl at ARRAY_DIM=4: load, reuse, stall gap, empty job, reset, held start.
module tb_systolic_array_ctrl;
   localparam int AD = 4;
   localparam int RW = 2;
   localparam int CW = 8;
`ifdef TPU_STALL_COUNT_EN
   localparam int STALL_EXP = 2;
`else
   localparam int STALL_EXP = 0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          reload_w = 1'b0;
   logic          w_valid = 1'b0;
   logic          x_valid = 1'b0;
   logic [CW-1:0] num_vectors = '0;
   logic          busy, done, instr, w_req, x_req;
   logic [RW-1:0] w_row_sel;
   logic [AD-1:0] w_load_en, row_feed_en, col_valid;
   logic [15:0]   stall_cycles;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0, instr_cnt = 0, xreq_cnt = 0;
   int last_cv3 = -10, done_at = -20;
   int col_cnt[AD] = '{default: 0};
   int feed_cnt[AD] = '{default: 0};
   int s_done, s_instr, s_xreq;
   int s_col[AD];
   int s_feed[AD];

   systolic_array_ctrl #(.ARRAY_DIM(AD), .ROW_W(RW), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .start(start), .reload_w(reload_w),
      .num_vectors(num_vectors), .busy(busy), .done(done), .instr(instr),
      .w_req(w_req), .w_valid(w_valid), .w_row_sel(w_row_sel), .w_load_en(w_load_en),
      .x_req(x_req), .x_valid(x_valid), .row_feed_en(row_feed_en),
      .col_valid(col_valid), .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   // event tallies, sampled mid-cycle
   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_at  <= cyc;
      end
      if (instr) instr_cnt <= instr_cnt + 1;
      if (x_req) xreq_cnt <= xreq_cnt + 1;
      if (col_valid[AD-1]) last_cv3 <= cyc;
      for (int j = 0; j < AD; j++) begin
         if (col_valid[j]) col_cnt[j] <= col_cnt[j] + 1;
         if (row_feed_en[j]) feed_cnt[j] <= feed_cnt[j] + 1;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic snap();
      s_done  = done_cnt;
      s_instr = instr_cnt;
      s_xreq  = xreq_cnt;
      for (int j = 0; j < AD; j++) begin
         s_col[j]  = col_cnt[j];
         s_feed[j] = feed_cnt[j];
      end
   endtask

   task automatic run_job(input logic rl, input int nv);
      start       = 1'b1;
      reload_w    = rl;
      num_vectors = CW'(nv);
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int n = 0;
      while (done !== 1'b1 && n < bound) begin
         step();
         n++;
      end
      chk(tag, done, 1);
   endtask

   task automatic chk_counts(input string tag, input int exp_pulses);
      for (int j = 0; j < AD; j++) begin
         chk($sformatf("%s_col%0d", tag, j), col_cnt[j] - s_col[j], exp_pulses);
         chk($sformatf("%s_feed%0d", tag, j), feed_cnt[j] - s_feed[j], exp_pulses);
      end
   endtask

   initial begin
      repeat (2) step();
      chk("rst_busy", busy, 0);
      chk("rst_outs", {done, instr, w_req, x_req}, 0);
      chk("rst_vec", {w_load_en, row_feed_en, col_valid}, 0);
      chk("rst_stall", stall_cycles, 0);
      reset = 1'b1;
      w_valid = 1'b1;
      x_valid = 1'b1;
      step();
      chk("idle_busy", busy, 0);

      // cold start: full weight load then three back-to-back vectors
      snap();
      run_job(1'b0, 3);
      chk("t1_busy", busy, 1);
      chk("t1_instr0", instr, 1);
      chk("t1_wreq", w_req, 1);
      chk("t1_sel0", w_row_sel, 0);
      chk("t1_ld_none", w_load_en, 0);
      step();
      chk("t1_sel1", w_row_sel, 1);
      chk("t1_ld0", w_load_en, 4'b0001);
      step();
      chk("t1_ld1", w_load_en, 4'b0010);
      step();
      chk("t1_ld2", w_load_en, 4'b0100);
      chk("t1_sel3", w_row_sel, 3);
      chk("t1_instr3", instr, 1);
      step();
      chk("t1_ld3", w_load_en, 4'b1000);
      chk("t1_instr_off", instr, 0);
      chk("t1_xreq_on", x_req, 1);
      step();
      chk("t1_feed_a", row_feed_en, 4'b0001);
      step();
      chk("t1_feed_b", row_feed_en, 4'b0011);
      step();
      chk("t1_feed_c", row_feed_en, 4'b0111);
      chk("t1_xreq_off", x_req, 0);
      step();
      chk("t1_feed_d", row_feed_en, 4'b1110);
      repeat (4) step();
      chk("t1_col_a", col_valid, 4'b1110);
      repeat (2) step();
      chk("t1_col_b", col_valid, 4'b1000);
      chk("t1_no_done_yet", done, 0);
      step();
      chk("t1_done", done, 1);
      chk("t1_busy_done", busy, 1);
      step();
      chk("t1_done_pulse", done, 0);
      chk("t1_busy_off", busy, 0);
      chk("t1_cv3_cnt", col_cnt[AD-1] - s_col[AD-1], 3);
      chk("t1_instr_cycles", instr_cnt - s_instr, 4);
      chk("t1_done_after", done_at, last_cv3 + 1);

      // weight reuse: no load phase
      snap();
      run_job(1'b0, 2);
      wait_done("t2_done", 40);
      repeat (2) step();
      chk("t2_no_instr", instr_cnt - s_instr, 0);
      chk("t2_done_cnt", done_cnt - s_done, 1);
      chk("t2_done_after", done_at, last_cv3 + 1);
      chk_counts("t2", 2);

      // two starved cycles between vectors
      snap();
      run_job(1'b0, 2);
      step();
      x_valid = 1'b0;
      step();
      step();
      chk("t3_xreq_held", x_req, 1);
      x_valid = 1'b1;
      step();
      chk("t3_feed_gap", row_feed_en, 4'b1001);
      chk("t3_stall", stall_cycles, STALL_EXP);
      repeat (4) step();
      chk("t3_col_gap", col_valid, 4'b1001);
      wait_done("t3_done", 40);
      step();
      chk_counts("t3", 2);
      chk("t3_stall_end", stall_cycles, STALL_EXP);

      // empty job
      snap();
      run_job(1'b0, 0);
      wait_done("t4_done", 2);
      step();
      chk("t4_no_xreq", xreq_cnt - s_xreq, 0);
      chk("t4_done_cnt", done_cnt - s_done, 1);
      chk_counts("t4", 0);

      // reset mid-compute, then weights must be reloaded
      run_job(1'b0, 5);
      step();
      step();
      reset = 1'b0;
      step();
      chk("t5_ctl", {busy, done, instr, w_req, x_req}, 0);
      chk("t5_vec", {w_load_en, row_feed_en, col_valid}, 0);
      chk("t5_stall", stall_cycles, 0);
      reset = 1'b1;
      snap();
      repeat (10) step();
      chk("t5_no_done", done_cnt - s_done, 0);
      chk("t5_idle", busy, 0);
      run_job(1'b0, 1);
      chk("t5_reload", instr, 1);
      wait_done("t5_done", 60);
      step();
      chk("t5_done_cnt", done_cnt - s_done, 1);

      // start held high through a job
      snap();
      start       = 1'b1;
      reload_w    = 1'b0;
      num_vectors = CW'(2);
      step();
      wait_done("t6_done", 40);
      start = 1'b0;
      repeat (3) step();
      chk("t6_done_cnt", done_cnt - s_done, 1);
      chk("t6_idle", busy, 0);
      chk("t6_cv3_cnt", col_cnt[AD-1] - s_col[AD-1], 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
